ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port RAM between two requesters: port 0 (CPU) and
// port 1 (loader). One transaction is served at a time through a small FSM:
//   IDLE   -> arbitrate and latch the winner's request
//   ACCESS -> drive the RAM, pulse gnt on the winner
//   RESP   -> (reads only) pulse rvalid on the winner with the captured data
//
// Parameters
//   PRIO_MODE   0 = round-robin on contention, 1 = port 0 always wins
//
// Ports
//   clk                 clock, everything updates on its rising edge
//   rst                 asynchronous reset, active low
//   req0/req1           access requests
//   we0/we1             1 = write, 0 = read (sampled with the request)
//   addr0/addr1         word address (sampled with the request)
//   wdata0/wdata1       write data (sampled with the request)
//   gnt0/gnt1           one-cycle "request accepted" pulse
//   rvalid0/rvalid1     one-cycle "read data valid" pulse
//   rdata0/rdata1       read data, held between reads
//   mem_addr/mem_din    RAM address / write data
//   mem_we              RAM write enable
//   mem_dout            RAM combinational read data
//   busy                high whenever the FSM is not in IDLE
module ram_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [7:0]  addr0,
    input  logic [7:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_we,
    input  logic [15:0] mem_dout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        win_q, win_d;      // port ID of the transaction in flight
    logic        last_q, last_d;    // port ID of the most recent grant
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;
    logic        pick;              // arbitration result for this cycle

    // Arbitration: a lone requester always wins; on a tie the mode decides.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            if (PRIO_MODE == 1) begin
                pick = 1'b0;
            end else begin
                pick = ~last_q;
            end
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        win_d    = win_q;
        last_d   = last_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d     = ACCESS;
                    win_d       = pick;
                    last_d      = pick;
                    we_d        = pick ? we1    : we0;
                    addr_d      = pick ? addr1  : addr0;
                    wdata_d     = pick ? wdata1 : wdata0;
                    gnt_d[pick] = 1'b1;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d         = RESP;
                    rvalid_d[win_q] = 1'b1;
                    if (win_q) begin
                        rdata1_d = mem_dout;
                    end else begin
                        rdata0_d = mem_dout;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 16'h0000;
            win_q    <= 1'b0;
            last_q   <= 1'b1;   // port 0 takes the first tie
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            rdata0_q <= 16'h0000;
            rdata1_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            win_q    <= win_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // mem_we is decoded from the state register, so an asynchronous reset
    // clearing state_q drops it at once, without waiting for an edge.
    assign mem_we   = (state_q == ACCESS) && we_q;
    assign mem_addr = addr_q;
    assign mem_din  = wdata_q;
    assign gnt0     = gnt_q[0];
    assign gnt1     = gnt_q[1];
    assign rvalid0  = rvalid_q[0];
    assign rvalid1  = rvalid_q[1];
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = (state_q != IDLE);

endmodule
